// File: rtl/branch_target_stage_if.sv
// Handshake bundle for the branch-target stage: branch operands in, resolved next PC out.
interface branch_target_stage_if #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] pc_plus4;
  logic [DATA_W-1:0] offset;
  logic              branch;
  logic              branch_ne;
  logic              zero;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] next_pc;
  logic [DATA_W-1:0] target;
  logic              taken;
  logic [CNT_W-1:0]  taken_cnt;

  modport master (
    output in_valid, pc_plus4, offset, branch, branch_ne, zero, out_ready,
    input  in_ready, out_valid, next_pc, target, taken, taken_cnt
  );

  modport slave (
    input  in_valid, pc_plus4, offset, branch, branch_ne, zero, out_ready,
    output in_ready, out_valid, next_pc, target, taken, taken_cnt
  );
endinterface

// File: rtl/branch_target_stage.sv
// Registered branch resolution: target = pc_plus4 + offset, next-PC select, and a
// one-entry skid buffer so in_ready never depends combinationally on out_ready.
//
// state | meaning
// EMPTY | output register and skid register both empty
// ONE   | output register holds a beat, skid register empty
// TWO   | both registers full, input stalled
module branch_target_stage #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  input logic                   flush,
  branch_target_stage_if.slave  bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] next_pc;
    logic [DATA_W-1:0] target;
    logic              taken;
  } beat_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  state_t           state_nxt;
  beat_t            in_beat;
  beat_t            or_q;
  beat_t            sk_q;
  logic             or_valid;
  logic             sk_valid;
  logic             in_fire;
  logic             out_fire;
  logic             or_load_in;
  logic             or_load_sk;
  logic             sk_load;
  logic [CNT_W-1:0] cnt_q;

  always_comb begin
    in_beat         = '0;
    in_beat.target  = bus.pc_plus4 + bus.offset;
    in_beat.taken   = bus.branch & (bus.zero ^ bus.branch_ne);
    in_beat.next_pc = in_beat.taken ? in_beat.target : bus.pc_plus4;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      EMPTY: if (in_fire) state_nxt = ONE;
      ONE: begin
        if (in_fire && !out_fire)      state_nxt = TWO;
        else if (!in_fire && out_fire) state_nxt = EMPTY;
      end
      TWO:     if (out_fire) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
    // Flush wins over everything; an output fire this cycle still counts below.
    if (flush) state_nxt = EMPTY;
  end

  always_comb begin
    or_valid   = (state != EMPTY);
    sk_valid   = (state == TWO);
    in_fire    = bus.in_valid & ~sk_valid;
    out_fire   = or_valid & bus.out_ready;
    or_load_in = in_fire & ~flush & ((state == EMPTY) | ((state == ONE) & out_fire));
    or_load_sk = out_fire & ~flush & (state == TWO);
    sk_load    = in_fire & ~flush & (state == ONE) & ~out_fire;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      or_q <= '0;
      sk_q <= '0;
    end else begin
      if (or_load_in)      or_q <= in_beat;
      else if (or_load_sk) or_q <= sk_q;
      if (sk_load)         sk_q <= in_beat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (out_fire && or_q.taken && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CNT_ONE;
    end
  end

  assign bus.in_ready  = ~sk_valid;
  assign bus.out_valid = or_valid;
  assign bus.next_pc   = or_q.next_pc;
  assign bus.target    = or_q.target;
  assign bus.taken     = or_q.taken;
  assign bus.taken_cnt = cnt_q;

endmodule

// File: tb/tb_branch_target_stage.sv
// Directed bench for branch_target_stage: a two-deep queue model checked every cycle,
// plus literal expectations for the hand-worked scenarios.
module tb_branch_target_stage;

  localparam int DATA_W  = 64;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = 3;

  typedef struct {
    logic [63:0] np;
    logic [63:0] tgt;
    logic        tk;
  } mbeat_t;

  logic clk;
  logic rst_n;
  logic flush;

  branch_target_stage_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus_if ();

  branch_target_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus_if)
  );

  int     n_pass;
  int     n_total;
  mbeat_t m_q[$];
  int     m_cnt;
  bit     m_ofire;
  bit     m_ifire;
  mbeat_t m_new;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
  endtask

  // Model: the stage is a FIFO of depth two with a registered output.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_q.delete();
        m_cnt = 0;
      end else begin
        m_ofire = (m_q.size() > 0) && (bus_if.out_ready === 1'b1);
        m_ifire = (bus_if.in_valid === 1'b1) && (m_q.size() < 2);
        m_new.tgt = bus_if.pc_plus4 + bus_if.offset;
        m_new.tk  = bus_if.branch && (bus_if.branch_ne ? !bus_if.zero : bus_if.zero);
        m_new.np  = m_new.tk ? m_new.tgt : bus_if.pc_plus4;
        if (m_ofire) begin
          if (m_q[0].tk && m_cnt < CNT_MAX) m_cnt++;
          void'(m_q.pop_front());
        end
        if (flush) m_q.delete();
        else if (m_ifire) m_q.push_back(m_new);
      end
    end
  end

  always @(negedge clk) begin
    chk("in_ready", {63'd0, bus_if.in_ready}, {63'd0, (m_q.size() < 2)});
    chk("out_valid", {63'd0, bus_if.out_valid}, {63'd0, (m_q.size() > 0)});
    if (m_q.size() > 0) begin
      chk("next_pc", bus_if.next_pc, m_q[0].np);
      chk("target", bus_if.target, m_q[0].tgt);
      chk("taken", {63'd0, bus_if.taken}, {63'd0, m_q[0].tk});
    end
    chk("taken_cnt", {62'd0, bus_if.taken_cnt}, 64'(m_cnt));
  end

  // Called at posedge+1; returns at posedge+1 of the accepting edge.
  task automatic send(input logic [63:0] pc, input logic [63:0] off,
                      input logic br, input logic ne, input logic z);
    bit acc;
    int n;
    bus_if.pc_plus4  = pc;
    bus_if.offset    = off;
    bus_if.branch    = br;
    bus_if.branch_ne = ne;
    bus_if.zero      = z;
    bus_if.in_valid  = 1'b1;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 40) begin
      acc = bus_if.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk("send_timeout", 64'd0, 64'd1);
    bus_if.in_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    bus_if.in_valid = 1'b0;
    bus_if.pc_plus4 = '0;
    bus_if.offset = '0;
    bus_if.branch = 1'b0;
    bus_if.branch_ne = 1'b0;
    bus_if.zero = 1'b0;
    bus_if.out_ready = 1'b0;
    cycles(3);
    chk("rst_out_valid", {63'd0, bus_if.out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, bus_if.in_ready}, 64'd1);
    chk("rst_next_pc", bus_if.next_pc, 64'd0);
    chk("rst_cnt", {62'd0, bus_if.taken_cnt}, 64'd0);
    rst_n = 1'b1;
    cycles(1);

    // 1: BEQ taken
    bus_if.out_ready = 1'b1;
    send(64'h1004, 64'h20, 1'b1, 1'b0, 1'b1);
    chk("t1_valid", {63'd0, bus_if.out_valid}, 64'd1);
    chk("t1_target", bus_if.target, 64'h1024);
    chk("t1_next_pc", bus_if.next_pc, 64'h1024);
    chk("t1_taken", {63'd0, bus_if.taken}, 64'd1);
    cycles(1);
    chk("t1_cnt", {62'd0, bus_if.taken_cnt}, 64'd1);

    // 2: BNE not taken, negative offset
    send(64'h2000, 64'hFFFF_FFFF_FFFF_FFF0, 1'b1, 1'b1, 1'b1);
    chk("t2_target", bus_if.target, 64'h1FF0);
    chk("t2_next_pc", bus_if.next_pc, 64'h2000);
    chk("t2_taken", {63'd0, bus_if.taken}, 64'd0);
    cycles(1);
    chk("t2_cnt", {62'd0, bus_if.taken_cnt}, 64'd1);

    // 3: wrap-around
    send(64'hFFFF_FFFF_FFFF_FFFC, 64'h8, 1'b1, 1'b0, 1'b1);
    chk("t3_target", bus_if.target, 64'h4);
    chk("t3_next_pc", bus_if.next_pc, 64'h4);
    cycles(1);
    chk("t3_cnt", {62'd0, bus_if.taken_cnt}, 64'd2);

    // 4: back-pressure, A/B/C in order
    bus_if.out_ready = 1'b0;
    send(64'h100, 64'h10, 1'b1, 1'b0, 1'b0);
    send(64'h200, 64'h20, 1'b1, 1'b1, 1'b1);
    chk("t4_in_ready", {63'd0, bus_if.in_ready}, 64'd0);
    chk("t4_head", bus_if.target, 64'h110);
    fork
      send(64'h300, 64'h30, 1'b0, 1'b0, 1'b1);
      begin
        cycles(3);
        bus_if.out_ready = 1'b1;
      end
    join
    cycles(4);

    // 5: flush with two buffered and a concurrent input
    bus_if.out_ready = 1'b0;
    send(64'h400, 64'h40, 1'b1, 1'b0, 1'b1);
    send(64'h500, 64'h50, 1'b1, 1'b0, 1'b1);
    bus_if.pc_plus4 = 64'h600;
    bus_if.in_valid = 1'b1;
    flush = 1'b1;
    cycles(1);
    flush = 1'b0;
    bus_if.in_valid = 1'b0;
    chk("t5_valid", {63'd0, bus_if.out_valid}, 64'd0);
    chk("t5_in_ready", {63'd0, bus_if.in_ready}, 64'd1);
    // flush while one buffered and an input fires on the same edge
    send(64'h700, 64'h70, 1'b0, 1'b0, 1'b0);
    bus_if.pc_plus4 = 64'h800;
    bus_if.in_valid = 1'b1;
    flush = 1'b1;
    cycles(1);
    flush = 1'b0;
    bus_if.in_valid = 1'b0;
    chk("t5b_valid", {63'd0, bus_if.out_valid}, 64'd0);
    bus_if.out_ready = 1'b1;
    cycles(3);
    // flush coinciding with an output fire of a taken beat
    send(64'h900, 64'h90, 1'b1, 1'b1, 1'b0);
    flush = 1'b1;
    cycles(1);
    flush = 1'b0;
    cycles(2);

    // 6: saturation then mid-stream reset
    for (int i = 0; i < 5; i++) send(64'hA000 + 64'(i * 16), 64'h8, 1'b1, 1'b0, 1'b1);
    cycles(3);
    chk("t6_sat", {62'd0, bus_if.taken_cnt}, 64'd3);
    bus_if.out_ready = 1'b0;
    send(64'hB000, 64'h4, 1'b1, 1'b0, 1'b1);
    send(64'hC000, 64'h4, 1'b1, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", {63'd0, bus_if.out_valid}, 64'd0);
    chk("t6_rst_next_pc", bus_if.next_pc, 64'd0);
    chk("t6_rst_target", bus_if.target, 64'd0);
    chk("t6_rst_taken", {63'd0, bus_if.taken}, 64'd0);
    chk("t6_rst_cnt", {62'd0, bus_if.taken_cnt}, 64'd0);
    chk("t6_rst_in_ready", {63'd0, bus_if.in_ready}, 64'd1);
    cycles(2);
    rst_n = 1'b1;
    bus_if.out_ready = 1'b1;
    send(64'hD000, 64'h100, 1'b1, 1'b1, 1'b0);
    chk("t6_resume_np", bus_if.next_pc, 64'hD100);
    cycles(3);
    chk("t6_resume_cnt", {62'd0, bus_if.taken_cnt}, 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
